// File: rtl/collision_scan_unit_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Types and constants shared by collision_scan_unit, its interface and the
// seg_intersect comparator.
//   state_e  : FSM state encoding {IDLE, SCAN, REPORT}.
//   seg_t    : packed 2-D segment {x1, y1, x2, y2}, SEG_COORD_W bits per field.
//   orient_w : width of a signed orientation value for a given coordinate width.
//   ID_NONE  : line ID meaning "no segment".
// Optional feature macro used by this slice: COLLIDE_COLLINEAR_EN.
// -----------------------------------------------------------------------------
package collision_pkg;

    // Coordinate width carried by seg_t. The top-level COORD_W parameter must
    // equal this value, because segments are packed into seg_t.
    localparam int SEG_COORD_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_e;

    typedef struct packed {
        logic [SEG_COORD_W-1:0] x1;
        logic [SEG_COORD_W-1:0] y1;
        logic [SEG_COORD_W-1:0] x2;
        logic [SEG_COORD_W-1:0] y2;
    } seg_t;

    // Coordinate differences need COORD_W+1 signed bits, each product
    // 2*COORD_W+2, and the difference of two products 2*COORD_W+3.
    function automatic int orient_w(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

    localparam int ORIENT_W = orient_w(SEG_COORD_W);

    localparam int ID_NONE = 0;

endpackage

// File: rtl/collision_scan_unit_if.sv
// -----------------------------------------------------------------------------
// collision_scan_unit_if
// Segment input and result output of collision_scan_unit.
//   master : segment feeder side (drives in_val and coordinates, sees results).
//   slave  : collision_scan_unit side.
// Signals: in_val, in_rdy, x1, y1, z1, x2, y2, z2 (segment in);
//          out_val, collide, lineID, hitID (result); busy (scan in progress).
//
// Handshake: a segment transfers on a rising clk edge where in_val and in_rdy
// are both 1; at any other edge the segment inputs are ignored. in_rdy is high
// only while the unit is idle and never depends on in_val. out_val is a
// single-cycle strobe with no back-pressure; collide, lineID and hitID are
// meaningful only while out_val is 1.
// -----------------------------------------------------------------------------
interface collision_scan_unit_if #(
    parameter int COORD_W = 8,
    parameter int ID_W    = 8
);
    logic               in_val;
    logic               in_rdy;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] z1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] z2;
    logic               out_val;
    logic               collide;
    logic [ID_W-1:0]    lineID;
    logic [ID_W-1:0]    hitID;
    logic               busy;

    modport master (
        output in_val, x1, y1, z1, x2, y2, z2,
        input  in_rdy, out_val, collide, lineID, hitID, busy
    );

    modport slave (
        input  in_val, x1, y1, z1, x2, y2, z2,
        output in_rdy, out_val, collide, lineID, hitID, busy
    );

endinterface

// File: rtl/collision_scan_unit_seg_intersect.sv
// -----------------------------------------------------------------------------
// seg_intersect
// Combinational test of whether two 2-D segments collide, using exact integer
// orientation arithmetic.
//   seg_a : segment A (seg_t)
//   seg_b : segment B (seg_t)
//   hit   : 1 when A and B collide
// Default build: only proper crossings (both orientation pairs strictly of
// opposite sign) count. With COLLIDE_COLLINEAR_EN defined, any zero
// orientation whose touching endpoint lies inside the other segment's bounding
// box also counts (touch, T-junction, collinear overlap).
// -----------------------------------------------------------------------------
module seg_intersect
    import collision_pkg::*;
(
    input  seg_t seg_a,
    input  seg_t seg_b,
    output logic hit
);

    localparam int CW = SEG_COORD_W;
    localparam int OW = ORIENT_W;

    typedef logic signed [OW-1:0] orient_t;

    // o(p,q,r) = (qx-px)(ry-py) - (qy-py)(rx-px)
    function automatic orient_t orient(
        input logic [CW-1:0] px, input logic [CW-1:0] py,
        input logic [CW-1:0] qx, input logic [CW-1:0] qy,
        input logic [CW-1:0] rx, input logic [CW-1:0] ry
    );
        logic signed [CW:0] dqx, dqy, drx, dry;
        orient_t p0, p1;
        dqx = $signed({1'b0, qx}) - $signed({1'b0, px});
        dqy = $signed({1'b0, qy}) - $signed({1'b0, py});
        drx = $signed({1'b0, rx}) - $signed({1'b0, px});
        dry = $signed({1'b0, ry}) - $signed({1'b0, py});
        p0  = OW'(dqx) * OW'(dry);
        p1  = OW'(dqy) * OW'(drx);
        return p0 - p1;
    endfunction

    // Strictly opposite signs: both non-zero and sign bits differ.
    function automatic logic opposite(input orient_t a, input orient_t b);
        return (a != '0) && (b != '0) && (a[OW-1] ^ b[OW-1]);
    endfunction

    orient_t o_ab_c, o_ab_d, o_cd_a, o_cd_b;

    always_comb begin
        o_ab_c = orient(seg_a.x1, seg_a.y1, seg_a.x2, seg_a.y2, seg_b.x1, seg_b.y1);
        o_ab_d = orient(seg_a.x1, seg_a.y1, seg_a.x2, seg_a.y2, seg_b.x2, seg_b.y2);
        o_cd_a = orient(seg_b.x1, seg_b.y1, seg_b.x2, seg_b.y2, seg_a.x1, seg_a.y1);
        o_cd_b = orient(seg_b.x1, seg_b.y1, seg_b.x2, seg_b.y2, seg_a.x2, seg_a.y2);
    end

`ifdef COLLIDE_COLLINEAR_EN
    // Point (px,py) inside the bounding box of segment s.
    function automatic logic in_box(input seg_t s, input logic [CW-1:0] px,
                                    input logic [CW-1:0] py);
        logic [CW-1:0] lo_x, hi_x, lo_y, hi_y;
        lo_x = (s.x1 < s.x2) ? s.x1 : s.x2;
        hi_x = (s.x1 < s.x2) ? s.x2 : s.x1;
        lo_y = (s.y1 < s.y2) ? s.y1 : s.y2;
        hi_y = (s.y1 < s.y2) ? s.y2 : s.y1;
        return (px >= lo_x) && (px <= hi_x) && (py >= lo_y) && (py <= hi_y);
    endfunction

    // A zero orientation means the tested endpoint is collinear with the other
    // segment; it lies in its own segment's box trivially, so only the other
    // box needs checking.
    always_comb begin
        hit = (opposite(o_ab_c, o_ab_d) && opposite(o_cd_a, o_cd_b))
            || ((o_ab_c == '0) && in_box(seg_a, seg_b.x1, seg_b.y1))
            || ((o_ab_d == '0) && in_box(seg_a, seg_b.x2, seg_b.y2))
            || ((o_cd_a == '0) && in_box(seg_b, seg_a.x1, seg_a.y1))
            || ((o_cd_b == '0) && in_box(seg_b, seg_a.x2, seg_a.y2));
    end
`else
    always_comb begin
        hit = opposite(o_ab_c, o_ab_d) && opposite(o_cd_a, o_cd_b);
    end
`endif

endmodule

// File: rtl/collision_scan_unit.sv
// -----------------------------------------------------------------------------
// collision_scan_unit
// Buffers the toolpath segments of the current layer (ring of DEPTH entries)
// and tests each new segment against every buffered one, oldest first,
// reporting the first collision.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   bus       : collision_scan_unit_if.slave (segment in, result out, busy)
//   dbg_state : current FSM state (collision_pkg::state_e encoding)
// Parameters: COORD_W (must equal collision_pkg::SEG_COORD_W), DEPTH (>=2),
// ID_W (line ID width, ID 0 = none).
// Optional feature macro: COLLIDE_COLLINEAR_EN (evaluated in seg_intersect).
// Latency from accept edge to out_val: compares performed + 2 cycles;
// an inter-layer move (z1 != z2) reports after 1 cycle.
// -----------------------------------------------------------------------------
module collision_scan_unit
    import collision_pkg::*;
#(
    parameter int COORD_W = SEG_COORD_W,
    parameter int DEPTH   = 16,
    parameter int ID_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    collision_scan_unit_if.slave bus,
    output logic [1:0]           dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SCAN   = SCAN;
    localparam logic [1:0] ST_REPORT = REPORT;

    logic [1:0]         state;
    seg_t               seg_buf [DEPTH];
    logic [ID_W-1:0]    id_buf  [DEPTH];
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [COORD_W-1:0] layer_z;
    logic [ID_W-1:0]    next_id;

    seg_t               cur_seg;
    logic [ID_W-1:0]    cur_id;
    logic               cur_store;
    logic [CNT_W-1:0]   scan_idx;
    logic [CNT_W-1:0]   scan_len;
    logic               hit_q;
    logic [ID_W-1:0]    hit_id_q;

    logic               accept;
    logic               skip_last;
    logic [PTR_W-1:0]   newest_ptr;
    logic [PTR_W-1:0]   scan_ptr;
    logic               hit_now;
    seg_t               in_seg;

    assign bus.in_rdy  = (state == ST_IDLE) && reset;
    assign bus.out_val = (state == ST_REPORT);
    assign bus.busy    = (state == ST_SCAN);
    assign bus.collide = hit_q;
    assign bus.hitID   = hit_id_q;
    assign bus.lineID  = cur_id;
    assign dbg_state   = state;

    assign accept = bus.in_val && bus.in_rdy;
    assign in_seg = '{x1: bus.x1, y1: bus.y1, x2: bus.x2, y2: bus.y2};

    always_comb begin
        int oldest_i;
        int phys_i;
        newest_ptr = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - 1'b1;
        // Logical scan index k maps onto the ring starting at the oldest entry.
        oldest_i = int'(wr_ptr) - int'(count);
        if (oldest_i < 0) oldest_i = oldest_i + DEPTH;
        phys_i = oldest_i + int'(scan_idx);
        if (phys_i >= DEPTH) phys_i = phys_i - DEPTH;
        scan_ptr = PTR_W'(phys_i);
        // A new segment that starts where the newest one ended is a continuing
        // path; that shared endpoint is not a collision, so the newest entry is
        // simply left out of the scan.
        skip_last = (count != '0)
                 && (seg_buf[newest_ptr].x2 == bus.x1)
                 && (seg_buf[newest_ptr].y2 == bus.y1);
    end

    seg_intersect u_seg_intersect (
        .seg_a (cur_seg),
        .seg_b (seg_buf[scan_ptr]),
        .hit   (hit_now)
    );

    // The compare result is registered before the FSM acts on it, so each
    // compare cycle is followed by one decision cycle: a hit on entry k leaves
    // SCAN one cycle later, and a full miss leaves after the cycle with
    // scan_idx == scan_len (which performs no compare).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            layer_z   <= '0;
            next_id   <= ID_W'(1);
            cur_seg   <= '0;
            cur_id    <= '0;
            cur_store <= 1'b0;
            scan_idx  <= '0;
            scan_len  <= '0;
            hit_q     <= 1'b0;
            hit_id_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_seg  <= in_seg;
                        cur_id   <= next_id;
                        next_id  <= (next_id == {ID_W{1'b1}}) ? ID_W'(1) : next_id + 1'b1;
                        hit_q    <= 1'b0;
                        hit_id_q <= ID_W'(ID_NONE);
                        scan_idx <= '0;
                        if (bus.z1 != bus.z2) begin
                            count     <= '0;
                            wr_ptr    <= '0;
                            layer_z   <= bus.z2;
                            cur_store <= 1'b0;
                            state     <= ST_REPORT;
                        end else if (bus.z1 != layer_z) begin
                            count     <= '0;
                            wr_ptr    <= '0;
                            layer_z   <= bus.z1;
                            cur_store <= 1'b1;
                            scan_len  <= '0;
                            state     <= ST_SCAN;
                        end else begin
                            cur_store <= 1'b1;
                            scan_len  <= count - CNT_W'(skip_last);
                            state     <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (hit_q || (scan_idx == scan_len)) begin
                        state <= ST_REPORT;
                    end else begin
                        if (hit_now) begin
                            hit_q    <= 1'b1;
                            hit_id_q <= id_buf[scan_ptr];
                        end
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (cur_store) begin
                        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                        // When full, the write slot is the oldest entry, which
                        // is overwritten; count stays saturated.
                        if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Segment storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if ((state == ST_REPORT) && cur_store) begin
            seg_buf[wr_ptr] <= cur_seg;
            id_buf[wr_ptr]  <= cur_id;
        end
    end

endmodule

// File: tb/tb_collision_scan_unit.sv
// -----------------------------------------------------------------------------
// tb_collision_scan_unit
// Directed, table-driven bench for collision_scan_unit. dut_a uses DEPTH=16,
// ID_W=8; dut_b uses DEPTH=4, ID_W=3 so ring eviction and ID wrap are reachable
// in a few segments. Expectations for the T-touch case follow
// COLLIDE_COLLINEAR_EN.
// -----------------------------------------------------------------------------
module tb_collision_scan_unit;
    import collision_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    collision_scan_unit_if #(.COORD_W(8), .ID_W(8)) bus_a ();
    collision_scan_unit_if #(.COORD_W(8), .ID_W(3)) bus_b ();
    logic [1:0] dbg_a, dbg_b;

    collision_scan_unit #(.COORD_W(8), .DEPTH(16), .ID_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave), .dbg_state(dbg_a)
    );
    collision_scan_unit #(.COORD_W(8), .DEPTH(4), .ID_W(3)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave), .dbg_state(dbg_b)
    );

    // ---------------- drive / monitor muxing ----------------
    int         cur_sel = 0;
    logic       d_val   = 1'b0;
    logic [7:0] d_x1 = '0, d_y1 = '0, d_z1 = '0, d_x2 = '0, d_y2 = '0, d_z2 = '0;

    assign bus_a.in_val = d_val && (cur_sel == 0);
    assign bus_b.in_val = d_val && (cur_sel == 1);
    assign bus_a.x1 = d_x1; assign bus_a.y1 = d_y1; assign bus_a.z1 = d_z1;
    assign bus_a.x2 = d_x2; assign bus_a.y2 = d_y2; assign bus_a.z2 = d_z2;
    assign bus_b.x1 = d_x1; assign bus_b.y1 = d_y1; assign bus_b.z1 = d_z1;
    assign bus_b.x2 = d_x2; assign bus_b.y2 = d_y2; assign bus_b.z2 = d_z2;

    logic       m_in_rdy, m_out_val, m_collide, m_busy;
    logic [7:0] m_line, m_hit;
    assign m_in_rdy  = (cur_sel == 1) ? bus_b.in_rdy  : bus_a.in_rdy;
    assign m_out_val = (cur_sel == 1) ? bus_b.out_val : bus_a.out_val;
    assign m_collide = (cur_sel == 1) ? bus_b.collide : bus_a.collide;
    assign m_busy    = (cur_sel == 1) ? bus_b.busy    : bus_a.busy;
    assign m_line    = (cur_sel == 1) ? {5'b0, bus_b.lineID} : bus_a.lineID;
    assign m_hit     = (cur_sel == 1) ? {5'b0, bus_b.hitID}  : bus_a.hitID;

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];   // {collide, hitID, lineID}

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        string name;
        int    sel;
        bit    rst;
        int    x1, y1, z1, x2, y2, z2;
        int    collide, hit, line, lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input int sel, input bit rst,
                       input int x1, input int y1, input int z1,
                       input int x2, input int y2, input int z2,
                       input int collide, input int hit, input int line, input int lat);
        vec_t v;
        v.name = name; v.sel = sel; v.rst = rst;
        v.x1 = x1; v.y1 = y1; v.z1 = z1; v.x2 = x2; v.y2 = y2; v.z2 = z2;
        v.collide = collide; v.hit = hit; v.line = line; v.lat = lat;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        d_val = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (m_in_rdy) ok = 1'b1;
        end
        if (!ok) check({name, "_rdy_timeout"}, 0, 1);
    endtask

    // Present a segment at a negedge; the following posedge is the accept edge.
    task automatic drive_seg(input vec_t v);
        d_x1 = 8'(v.x1); d_y1 = 8'(v.y1); d_z1 = 8'(v.z1);
        d_x2 = 8'(v.x2); d_y2 = 8'(v.y2); d_z2 = 8'(v.z2);
        d_val = 1'b1;
        @(posedge clk);
        #1 d_val = 1'b0;
    endtask

    task automatic send_and_check(input vec_t v);
        logic [16:0] e;
        logic [16:0] exp_rec;
        bit seen;
        int lat;
        int hv, lv;
        cur_sel = v.sel;
        hv = v.hit; lv = v.line;
        wait_ready(v.name);
        e = {v.collide[0], hv[7:0], lv[7:0]};
        exp_q.push_back(e);
        drive_seg(v);
        check({v.name, "_rdy_low"}, int'(m_in_rdy), 0);
        seen = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (m_out_val) begin
                seen = 1'b1;
                lat = c;
            end
        end
        exp_rec = exp_q.pop_front();
        if (!seen) begin
            check({v.name, "_outval_timeout"}, 0, 1);
        end else begin
            check({v.name, "_latency"}, lat, v.lat);
            check({v.name, "_collide"}, int'(m_collide), int'(exp_rec[16]));
            check({v.name, "_hitID"},   int'(m_hit),     int'(exp_rec[15:8]));
            check({v.name, "_lineID"},  int'(m_line),    int'(exp_rec[7:0]));
            @(posedge clk);
            #1;
            check({v.name, "_strobe_1cyc"}, int'(m_out_val), 0);
            check({v.name, "_rdy_back"},    int'(m_in_rdy),  1);
        end
    endtask

`ifdef COLLIDE_COLLINEAR_EN
    localparam int T_COL = 1;
    localparam int T_HIT = 1;
`else
    localparam int T_COL = 0;
    localparam int T_HIT = 0;
`endif

    // ---------------- test ----------------
    initial begin
        vec_t v;
        reset = 1'b0;

        //   name        sel rst  x1 y1 z1  x2 y2 z2  col hit line lat
        add("cross_a",    0, 1,   0, 0, 5, 10,10, 5,  0,  0,  1,  2);
        add("cross_b",    0, 0,   0,10, 5, 10, 0, 5,  1,  1,  2,  3);
        add("chain_a",    0, 1,   0, 0, 0, 10, 0, 0,  0,  0,  1,  2);
        add("chain_b",    0, 0,  10, 0, 0, 10,10, 0,  0,  0,  2,  2);
        add("tee_a",      0, 1,   0, 0, 0, 10, 0, 0,  0,  0,  1,  2);
        add("tee_b",      0, 0,   5, 0, 0,  5, 9, 0, T_COL, T_HIT, 2, 3);
        add("layer_s1",   0, 1,   0, 0, 2,  1, 0, 2,  0,  0,  1,  2);
        add("layer_s2",   0, 0,   0, 2, 2,  1, 2, 2,  0,  0,  2,  3);
        add("layer_s3",   0, 0,   0, 4, 2,  1, 4, 2,  0,  0,  3,  4);
        add("layer_move", 0, 0,   5, 5, 2,  5, 5, 3,  0,  0,  4,  1);
        add("layer_new",  0, 0,   0, 3, 3,  1, 1, 3,  0,  0,  5,  2);
        // DEPTH=4 ring: six stacked horizontals, then a crossing of id1 only.
        add("ring1_1",    1, 1,   0, 2, 0,  1, 2, 0,  0,  0,  1,  2);
        add("ring1_2",    1, 0,   0, 4, 0,  1, 4, 0,  0,  0,  2,  3);
        add("ring1_3",    1, 0,   0, 6, 0,  1, 6, 0,  0,  0,  3,  4);
        add("ring1_4",    1, 0,   0, 8, 0,  1, 8, 0,  0,  0,  4,  5);
        add("ring1_5",    1, 0,   0,10, 0,  1,10, 0,  0,  0,  5,  6);
        add("ring1_6",    1, 0,   0,12, 0,  1,12, 0,  0,  0,  6,  6);
        add("ring1_evict",1, 0,   0, 1, 0,  1, 3, 0,  0,  0,  7,  6);
        add("ring1_wrap", 1, 0,   5, 5, 0,  5, 5, 1,  0,  0,  1,  1);
        // Same fill, then a crossing of id3 (now the oldest entry).
        add("ring2_1",    1, 1,   0, 2, 0,  1, 2, 0,  0,  0,  1,  2);
        add("ring2_2",    1, 0,   0, 4, 0,  1, 4, 0,  0,  0,  2,  3);
        add("ring2_3",    1, 0,   0, 6, 0,  1, 6, 0,  0,  0,  3,  4);
        add("ring2_4",    1, 0,   0, 8, 0,  1, 8, 0,  0,  0,  4,  5);
        add("ring2_5",    1, 0,   0,10, 0,  1,10, 0,  0,  0,  5,  6);
        add("ring2_6",    1, 0,   0,12, 0,  1,12, 0,  0,  0,  6,  6);
        add("ring2_hit3", 1, 0,   0, 5, 0,  1, 7, 0,  1,  3,  7,  3);

        // Reset-state outputs of both instances while reset is held low.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            cur_sel = s;
            #1;
            check("rst_out_val", int'(m_out_val), 0);
            check("rst_collide", int'(m_collide), 0);
            check("rst_lineID",  int'(m_line),    0);
            check("rst_hitID",   int'(m_hit),     0);
            check("rst_busy",    int'(m_busy),    0);
            check("rst_in_rdy",  int'(m_in_rdy),  0);
        end
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            send_and_check(vecs[i]);
        end

        // Reset asserted while the 4th segment is scanning.
        cur_sel = 0;
        do_reset();
        add("mid_1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2);
        add("mid_2", 0, 0, 0, 2, 0, 1, 2, 0, 0, 0, 2, 3);
        add("mid_3", 0, 0, 0, 4, 0, 1, 4, 0, 0, 0, 3, 4);
        for (int i = vecs.size() - 3; i < vecs.size(); i++) send_and_check(vecs[i]);
        wait_ready("mid_4");
        v = vecs[vecs.size() - 1];
        v.y1 = 6; v.y2 = 6;
        drive_seg(v);
        @(posedge clk);
        #1 check("mid_busy_in_scan", int'(m_busy), 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_rdy",  int'(m_in_rdy),  0);
        check("mid_rst_busy", int'(m_busy),    0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1 check("mid_rst_no_outval", int'(m_out_val), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        add("mid_after", 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 1, 2);
        send_and_check(vecs[vecs.size() - 1]);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
